// File: rtl/vga_image_loader_if.sv
// Byte-stream input and frame-buffer write/status bus of the VGA image loader.
// The master drives the stream. The slave (the loader) drives the write port and status.
interface vga_image_loader_if;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic        wr_en;
  logic [18:0] wr_addr;
  logic [7:0]  wr_data;
  logic [9:0]  image_width;
  logic [8:0]  image_height;
  logic        image_valid;
  logic        load_busy;
  logic        load_err;

  modport master (
    output in_data,
    output in_valid,
    input  in_ready,
    input  wr_en,
    input  wr_addr,
    input  wr_data,
    input  image_width,
    input  image_height,
    input  image_valid,
    input  load_busy,
    input  load_err
  );

  modport slave (
    input  in_data,
    input  in_valid,
    output in_ready,
    output wr_en,
    output wr_addr,
    output wr_data,
    output image_width,
    output image_height,
    output image_valid,
    output load_busy,
    output load_err
  );
endinterface

// File: rtl/vga_image_loader.sv
// Frame loader: parses a sync/width/height header from a byte stream and writes
// the following pixels linearly into the frame-buffer RAM starting at address 0.
module vga_image_loader #(
  parameter logic [7:0]  SYNC_BYTE = 8'hA5,
  parameter int unsigned MAX_W     = 640,
  parameter int unsigned MAX_H     = 480
) (
  input logic               clk,
  input logic               rst,
  input logic               clk_en,
  vga_image_loader_if.slave bus
);

  localparam logic [15:0] MaxW = 16'(MAX_W);
  localparam logic [15:0] MaxH = 16'(MAX_H);

  typedef enum logic [3:0] {
    StIdle,
    StHw0,
    StHw1,
    StHh0,
    StHh1,
    StCheck,
    StLoad,
    StDone,
    StErr
  } state_e;

  state_e      state_q, state_d;
  logic        ready_d;
  logic        in_ready_q;
  logic [15:0] w_q, h_q;
  logic [18:0] area;
  logic [18:0] pix_cnt_q;
  logic [18:0] remain_q;
  logic        wr_pend_q;
  logic [18:0] wr_addr_q;
  logic [7:0]  wr_data_q;
  logic [9:0]  img_w_q;
  logic [8:0]  img_h_q;
  logic        img_valid_q;
  logic        busy_q;
  logic        err_q;
  logic        accept;
  logic        is_sync;
  logic        hdr_ok;

  assign accept  = clk_en && bus.in_valid && in_ready_q;
  assign is_sync = (bus.in_data == SYNC_BYTE);

  // Full 16-bit compare so oversized values with small low bits are rejected.
  assign hdr_ok = (w_q != 16'd0) && (w_q <= MaxW) && (h_q != 16'd0) && (h_q <= MaxH);
  assign area   = 19'(w_q[9:0]) * 19'(h_q[8:0]);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (accept && is_sync) state_d = StHw0;
      StHw0:   if (accept) state_d = StHw1;
      StHw1:   if (accept) state_d = StHh0;
      StHh0:   if (accept) state_d = StHh1;
      StHh1:   if (accept) state_d = StCheck;
      StCheck: if (clk_en) state_d = hdr_ok ? StLoad : StErr;
      StLoad:  if (accept && remain_q == 19'd1) state_d = StDone;
      StDone:  if (clk_en) state_d = StIdle;
      StErr:   if (clk_en) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    ready_d = 1'b0;
    unique case (state_d)
      StIdle, StHw0, StHw1, StHh0, StHh1, StLoad: ready_d = 1'b1;
      default:                                     ready_d = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      in_ready_q  <= 1'b0;
      w_q         <= '0;
      h_q         <= '0;
      pix_cnt_q   <= '0;
      remain_q    <= '0;
      wr_pend_q   <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      img_w_q     <= '0;
      img_h_q     <= '0;
      img_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      err_q <= 1'b0;
      if (clk_en) begin
        in_ready_q <= ready_d;
        // A pending write is consumed by the first enabled cycle after acceptance.
        wr_pend_q  <= 1'b0;
        unique case (state_q)
          StIdle: begin
            if (accept && is_sync) busy_q <= 1'b1;
          end
          StHw0: begin
            if (accept) w_q[7:0] <= bus.in_data;
          end
          StHw1: begin
            if (accept) w_q[15:8] <= bus.in_data;
          end
          StHh0: begin
            if (accept) h_q[7:0] <= bus.in_data;
          end
          StHh1: begin
            if (accept) h_q[15:8] <= bus.in_data;
          end
          StCheck: begin
            if (hdr_ok) begin
              img_valid_q <= 1'b0;
              pix_cnt_q   <= '0;
              remain_q    <= area;
            end
          end
          StLoad: begin
            if (accept) begin
              wr_pend_q <= 1'b1;
              wr_addr_q <= pix_cnt_q;
              wr_data_q <= bus.in_data;
              pix_cnt_q <= pix_cnt_q + 19'd1;
              remain_q  <= remain_q - 19'd1;
            end
          end
          StDone: begin
            img_w_q     <= w_q[9:0];
            img_h_q     <= h_q[8:0];
            img_valid_q <= 1'b1;
            busy_q      <= 1'b0;
          end
          StErr: begin
            err_q  <= 1'b1;
            busy_q <= 1'b0;
          end
          default: ;
        endcase
      end
    end
  end

  assign bus.in_ready     = in_ready_q;
  assign bus.wr_en        = wr_pend_q & clk_en;
  assign bus.wr_addr      = wr_addr_q;
  assign bus.wr_data      = wr_data_q;
  assign bus.image_width  = img_w_q;
  assign bus.image_height = img_h_q;
  assign bus.image_valid  = img_valid_q;
  assign bus.load_busy    = busy_q;
  assign bus.load_err     = err_q;

endmodule

// File: tb/tb_vga_image_loader.sv
// Directed bench for vga_image_loader: a table of frames plus hand-written
// sequences for reset, latency, mid-load abort and valid-drop behaviour.
module tb_vga_image_loader;

  logic clk;
  logic rst;
  logic clk_en;

  vga_image_loader_if bus ();

  vga_image_loader dut (
    .clk    (clk),
    .rst    (rst),
    .clk_en (clk_en),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] w;
    logic [15:0] h;
    logic [7:0]  pix0;
    int          pre;
    bit          rnd;
    bit          alt;
    int          exp_err;
    int          exp_w;
    int          exp_h;
    int          exp_valid;
    int          exp_n;
  } vec_t;

  int          checks = 0;
  int          errors = 0;
  int          err_cycles = 0;
  logic [26:0] wr_log[$];
  vec_t        vecs[13];

  // Write monitor: records every strobe and flags any strobe without clk_en.
  always @(negedge clk) begin
    if (bus.wr_en === 1'b1) begin
      wr_log.push_back({bus.wr_addr, bus.wr_data});
      checks++;
      if (clk_en !== 1'b1) begin
        errors++;
        $display("FAIL wr_en_without_clk_en: got clk_en=%b required 1", clk_en);
      end
    end
    if (bus.load_err === 1'b1) err_cycles++;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  // Called and returns at posedge+2.
  task automatic idle(input int n);
    bus.in_valid = 1'b0;
    clk_en       = 1'b1;
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  // Returns at posedge+2 right after the edge that accepted the last byte.
  task automatic send_bytes(input logic [7:0] q[$], input bit rnd, input bit alt);
    int idx    = 0;
    int budget = 0;
    while (idx < q.size() && budget < 20000) begin
      bus.in_data  = q[idx];
      bus.in_valid = rnd ? ($urandom_range(1) == 1) : 1'b1;
      clk_en       = alt ? ~clk_en : 1'b1;
      @(negedge clk);
      if (clk_en && bus.in_valid && bus.in_ready) idx++;
      @(posedge clk);
      #2;
      budget++;
    end
    bus.in_valid = 1'b0;
    clk_en       = 1'b1;
    chk("send_complete", 32'(idx), 32'(q.size()));
  endtask

  task automatic run_vector(input int id, input vec_t v);
    logic [7:0] q[$];
    int bad;
    q = {};
    for (int i = 0; i < v.pre; i++) q.push_back((i == 0) ? 8'h12 : 8'h34);
    q.push_back(8'hA5);
    q.push_back(v.w[7:0]);
    q.push_back(v.w[15:8]);
    q.push_back(v.h[7:0]);
    q.push_back(v.h[15:8]);
    for (int i = 0; i < v.exp_n; i++) q.push_back(v.pix0 + 8'(i));
    wr_log.delete();
    err_cycles = 0;
    send_bytes(q, v.rnd, v.alt);
    idle(6);
    @(negedge clk);
    chk($sformatf("v%0d err_cycles", id), 32'(err_cycles), 32'(v.exp_err));
    chk($sformatf("v%0d write_count", id), 32'(wr_log.size()), 32'(v.exp_n));
    bad = -1;
    for (int i = 0; i < wr_log.size(); i++) begin
      if (wr_log[i] !== {19'(i), v.pix0 + 8'(i)}) begin
        bad = i;
        break;
      end
    end
    checks++;
    if (bad >= 0) begin
      errors++;
      $display("FAIL v%0d write_content: got addr/data %0h at entry %0d required %0h", id,
               wr_log[bad], bad, {19'(bad), v.pix0 + 8'(bad)});
    end
    chk($sformatf("v%0d image_width", id), 32'(bus.image_width), 32'(v.exp_w));
    chk($sformatf("v%0d image_height", id), 32'(bus.image_height), 32'(v.exp_h));
    chk($sformatf("v%0d image_valid", id), 32'(bus.image_valid), 32'(v.exp_valid));
    chk($sformatf("v%0d load_busy", id), 32'(bus.load_busy), 32'd0);
    chk($sformatf("v%0d in_ready", id), 32'(bus.in_ready), 32'd1);
    @(posedge clk);
    #2;
  endtask

  initial begin
    logic [7:0] q[$];
    vec_t       v;

    //          w         h          pix0   pre rnd alt err  ew   eh valid  n
    vecs[0]  = '{16'd4,    16'd3,     8'h00, 0, 0, 0, 0,   4,   3, 1,   12};
    vecs[1]  = '{16'h0281, 16'h0010,  8'h00, 0, 0, 0, 1,   4,   3, 1,    0};
    vecs[2]  = '{16'd2,    16'd2,     8'h40, 2, 0, 0, 0,   2,   2, 1,    4};
    vecs[3]  = '{16'd1,    16'd1,     8'hA5, 0, 0, 0, 0,   1,   1, 1,    1};
    vecs[4]  = '{16'd640,  16'd481,   8'h00, 0, 0, 0, 1,   1,   1, 1,    0};
    vecs[5]  = '{16'd0,    16'd5,     8'h00, 0, 0, 0, 1,   1,   1, 1,    0};
    vecs[6]  = '{16'd5,    16'd0,     8'h00, 0, 0, 0, 1,   1,   1, 1,    0};
    vecs[7]  = '{16'h0404, 16'd2,     8'h00, 0, 0, 0, 1,   1,   1, 1,    0};
    vecs[8]  = '{16'd64,   16'd8,     8'h80, 0, 1, 1, 0,  64,   8, 1,  512};
    vecs[9]  = '{16'd640,  16'd1,     8'h10, 0, 0, 0, 0, 640,   1, 1,  640};
    vecs[10] = '{16'd1,    16'd480,   8'h20, 0, 1, 0, 0,   1, 480, 1,  480};
    vecs[11] = '{16'h0104, 16'd2,     8'hF0, 0, 0, 1, 0, 260,   2, 1,  520};
    vecs[12] = '{16'd3,    16'h0101,  8'h07, 0, 0, 0, 0,   3, 257, 1,  771};

    // Reset is honoured even with clk_en low and a sync byte on the bus.
    rst          = 1'b0;
    clk_en       = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_data  = 8'hA5;
    repeat (3) @(posedge clk);
    #2;
    @(negedge clk);
    chk("rst in_ready", 32'(bus.in_ready), 32'd0);
    chk("rst wr_en", 32'(bus.wr_en), 32'd0);
    chk("rst wr_addr", 32'(bus.wr_addr), 32'd0);
    chk("rst wr_data", 32'(bus.wr_data), 32'd0);
    chk("rst dims", 32'({bus.image_width, bus.image_height}), 32'd0);
    chk("rst flags", 32'({bus.image_valid, bus.load_busy, bus.load_err}), 32'd0);
    @(posedge clk);
    #2;
    rst          = 1'b1;
    clk_en       = 1'b1;
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk("post_rst in_ready low", 32'(bus.in_ready), 32'd0);
    @(posedge clk);
    #2;
    @(negedge clk);
    chk("post_rst in_ready high", 32'(bus.in_ready), 32'd1);
    @(posedge clk);
    #2;

    for (int i = 0; i < 13; i++) run_vector(i, vecs[i]);

    // Max-size header accepted; image_valid drops while the new frame loads.
    wr_log.delete();
    err_cycles = 0;
    q = {8'hA5, 8'h80, 8'h02, 8'hE0, 8'h01, 8'h11, 8'h22, 8'h33};
    send_bytes(q, 1'b0, 1'b0);
    idle(2);
    @(negedge clk);
    chk("max load_busy", 32'(bus.load_busy), 32'd1);
    chk("max image_valid", 32'(bus.image_valid), 32'd0);
    chk("max in_ready", 32'(bus.in_ready), 32'd1);
    chk("max err_cycles", 32'(err_cycles), 32'd0);
    chk("max write_count", 32'(wr_log.size()), 32'd3);
    if (wr_log.size() == 3) chk("max last_write", 32'(wr_log[2]), 32'({19'd2, 8'h33}));
    @(posedge clk);
    #2;
    rst = 1'b0;
    idle(2);
    rst = 1'b1;
    idle(2);
    run_vector(13, vecs[3]);

    // Reset after 5 of 12 pixels: write latency, then everything cleared.
    wr_log.delete();
    q = {8'hA5, 8'h04, 8'h00, 8'h03, 8'h00, 8'h50, 8'h51, 8'h52, 8'h53, 8'h54};
    send_bytes(q, 1'b0, 1'b0);
    rst = 1'b0;
    @(negedge clk);
    chk("abort load_busy", 32'(bus.load_busy), 32'd1);
    chk("abort latency wr_en", 32'(bus.wr_en), 32'd1);
    chk("abort latency wr_addr", 32'(bus.wr_addr), 32'd4);
    chk("abort latency wr_data", 32'(bus.wr_data), 32'h54);
    @(posedge clk);
    #2;
    @(negedge clk);
    chk("abort wr", 32'({bus.wr_en, bus.wr_addr, bus.wr_data}), 32'd0);
    chk("abort dims", 32'({bus.image_width, bus.image_height}), 32'd0);
    chk("abort flags", 32'({bus.image_valid, bus.load_busy, bus.load_err}), 32'd0);
    chk("abort in_ready", 32'(bus.in_ready), 32'd0);
    @(posedge clk);
    #2;
    rst = 1'b1;
    idle(3);
    chk("abort write_count", 32'(wr_log.size()), 32'd5);

    v = '{16'd2, 16'd1, 8'h60, 0, 0, 0, 0, 2, 1, 1, 2};
    run_vector(14, v);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
